// File: rtl/int_iq_pkg.sv
// Shared types for the integer ALU issue queue.
// Op codes, tag widths, entry layout and the wakeup helper.
package int_iq_pkg;

    localparam int IQ_TAG_W = 7;
    localparam int IQ_ROB_W = 8;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;

    typedef struct packed {
        logic                rdy;
        logic [IQ_TAG_W-1:0] tag;
        logic [63:0]         val;
    } iq_src_t;

    typedef struct packed {
        logic                valid;
        logic [3:0]          alu_ctrl;
        iq_src_t             src1;
        iq_src_t             src2;
        logic [IQ_TAG_W-1:0] dest_phys;
        logic [IQ_ROB_W-1:0] rob_idx;
    } iq_entry_t;

    // Capture a writeback into a waiting operand; pipe0 has priority.
    function automatic iq_src_t iq_wake(
        input iq_src_t               s,
        input logic [1:0]            v,
        input logic [2*IQ_TAG_W-1:0] t,
        input logic [127:0]          d
    );
        iq_src_t r;
        r = s;
        if (!s.rdy) begin
            if (v[0] && s.tag == t[IQ_TAG_W-1:0]) begin
                r.rdy = 1'b1;
                r.val = d[63:0];
            end else if (v[1] && s.tag == t[2*IQ_TAG_W-1:IQ_TAG_W]) begin
                r.rdy = 1'b1;
                r.val = d[127:64];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch, writeback and issue bundle of the ALU issue queue.
// The queue is the slave; dispatch/ALU side is the master.
interface alu_issue_queue_if;
    import int_iq_pkg::*;

    logic                  disp_valid_i;
    logic                  disp_ready_o;
    logic [3:0]            disp_alu_ctrl_i;
    logic                  disp_src1_rdy_i;
    logic [IQ_TAG_W-1:0]   disp_src1_tag_i;
    logic [63:0]           disp_src1_val_i;
    logic                  disp_src2_rdy_i;
    logic [IQ_TAG_W-1:0]   disp_src2_tag_i;
    logic [63:0]           disp_src2_val_i;
    logic [IQ_TAG_W-1:0]   disp_dest_phys_i;
    logic [IQ_ROB_W-1:0]   disp_rob_idx_i;
    logic [1:0]            wb_valid_i;
    logic [2*IQ_TAG_W-1:0] wb_tag_i;
    logic [127:0]          wb_data_i;
    logic [1:0]            iss_valid_o;
    logic [127:0]          iss_op1_o;
    logic [127:0]          iss_op2_o;
    logic [7:0]            iss_alu_ctrl_o;
    logic [2*IQ_TAG_W-1:0] iss_dest_phys_o;
    logic [2*IQ_ROB_W-1:0] iss_rob_idx_o;

    modport master (
        output disp_valid_i, disp_alu_ctrl_i,
        output disp_src1_rdy_i, disp_src1_tag_i, disp_src1_val_i,
        output disp_src2_rdy_i, disp_src2_tag_i, disp_src2_val_i,
        output disp_dest_phys_i, disp_rob_idx_i,
        output wb_valid_i, wb_tag_i, wb_data_i,
        input  disp_ready_o, iss_valid_o, iss_op1_o, iss_op2_o,
        input  iss_alu_ctrl_o, iss_dest_phys_o, iss_rob_idx_o
    );

    modport slave (
        input  disp_valid_i, disp_alu_ctrl_i,
        input  disp_src1_rdy_i, disp_src1_tag_i, disp_src1_val_i,
        input  disp_src2_rdy_i, disp_src2_tag_i, disp_src2_val_i,
        input  disp_dest_phys_i, disp_rob_idx_i,
        input  wb_valid_i, wb_tag_i, wb_data_i,
        output disp_ready_o, iss_valid_o, iss_op1_o, iss_op2_o,
        output iss_alu_ctrl_o, iss_dest_phys_o, iss_rob_idx_o
    );

endinterface

// File: rtl/iq_age_select.sv
// Picks the oldest and second-oldest ready entries from an age matrix.
// age_i[i][j] set means entry j is older than entry i.
module iq_age_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0][DEPTH-1:0] age_i,
    input  logic [DEPTH-1:0]            rdy_i,
    output logic [DEPTH-1:0]            gnt0_o,
    output logic [DEPTH-1:0]            gnt1_o,
    output logic                        vld0_o,
    output logic                        vld1_o
);

    logic [DEPTH-1:0] rdy2;

    always_comb begin
        gnt0_o = '0;
        gnt1_o = '0;
        for (int i = 0; i < DEPTH; i++)
            gnt0_o[i] = rdy_i[i] && ((age_i[i] & rdy_i) == '0);
        rdy2 = rdy_i & ~gnt0_o;
        for (int i = 0; i < DEPTH; i++)
            gnt1_o[i] = rdy2[i] && ((age_i[i] & rdy2) == '0);
    end

    assign vld0_o = |gnt0_o;
    assign vld1_o = |gnt1_o;

endmodule

// File: rtl/alu_issue_queue.sv
// Data-capture issue queue feeding the two 64-bit ALU pipes.
// Wakes operands from both writeback buses; issues oldest two ready.
module alu_issue_queue
    import int_iq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    input logic             flush_i,
    alu_issue_queue_if.slave io
);

    localparam int IDX_W = $clog2(DEPTH);

    iq_entry_t [DEPTH-1:0]            ent_q, ent_d;
    logic [DEPTH-1:0][DEPTH-1:0]      age_q, age_d;
    logic [DEPTH-1:0]                 occ, rdy, gnt0, gnt1, iss_v;
    logic                             vld0, vld1, not_full, alloc;
    logic [IDX_W-1:0]                 alloc_idx;
    iq_entry_t                        new_ent, sel0, sel1;

    always_comb begin
        occ = '0;
        rdy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = ent_q[i].valid;
            rdy[i] = ent_q[i].valid && ent_q[i].src1.rdy
                     && ent_q[i].src2.rdy;
        end
    end

    iq_age_select #(.DEPTH(DEPTH)) u_sel (
        .age_i  (age_q),
        .rdy_i  (rdy),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1),
        .vld0_o (vld0),
        .vld1_o (vld1)
    );

    assign iss_v    = gnt0 | gnt1;
    assign not_full = ~&occ;
    assign alloc    = io.disp_valid_i && not_full && !flush_i;
    assign io.disp_ready_o = not_full;

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!occ[i]) alloc_idx = IDX_W'(i);
    end

    // Dispatched operands see the same-cycle writeback too.
    always_comb begin
        new_ent           = '0;
        new_ent.valid     = 1'b1;
        new_ent.alu_ctrl  = io.disp_alu_ctrl_i;
        new_ent.src1.rdy  = io.disp_src1_rdy_i;
        new_ent.src1.tag  = io.disp_src1_tag_i;
        new_ent.src1.val  = io.disp_src1_val_i;
        new_ent.src2.rdy  = io.disp_src2_rdy_i;
        new_ent.src2.tag  = io.disp_src2_tag_i;
        new_ent.src2.val  = io.disp_src2_val_i;
        new_ent.dest_phys = io.disp_dest_phys_i;
        new_ent.rob_idx   = io.disp_rob_idx_i;
        new_ent.src1 = iq_wake(new_ent.src1, io.wb_valid_i,
                               io.wb_tag_i, io.wb_data_i);
        new_ent.src2 = iq_wake(new_ent.src2, io.wb_valid_i,
                               io.wb_tag_i, io.wb_data_i);
    end

    always_comb begin
        ent_d = ent_q;
        age_d = age_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i].src1 = iq_wake(ent_q[i].src1, io.wb_valid_i,
                                    io.wb_tag_i, io.wb_data_i);
            ent_d[i].src2 = iq_wake(ent_q[i].src2, io.wb_valid_i,
                                    io.wb_tag_i, io.wb_data_i);
            if (iss_v[i]) ent_d[i].valid = 1'b0;
            age_d[i] = age_q[i] & ~iss_v;
        end
        if (alloc) begin
            ent_d[alloc_idx] = new_ent;
            age_d[alloc_idx] = occ & ~iss_v;
        end
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
            age_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '0;
            age_q <= '0;
        end else begin
            ent_q <= ent_d;
            age_q <= age_d;
        end
    end

    always_comb begin
        sel0 = '0;
        sel1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sel0 = sel0 | ({$bits(iq_entry_t){gnt0[i]}} & ent_q[i]);
            sel1 = sel1 | ({$bits(iq_entry_t){gnt1[i]}} & ent_q[i]);
        end
        if (flush_i) begin
            sel0 = '0;
            sel1 = '0;
        end
        io.iss_valid_o     = flush_i ? 2'b00 : {vld1, vld0};
        io.iss_op1_o       = {sel1.src1.val, sel0.src1.val};
        io.iss_op2_o       = {sel1.src2.val, sel0.src2.val};
        io.iss_alu_ctrl_o  = {sel1.alu_ctrl, sel0.alu_ctrl};
        io.iss_dest_phys_o = {sel1.dest_phys, sel0.dest_phys};
        io.iss_rob_idx_o   = {sel1.rob_idx, sel0.rob_idx};
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue.
// Hand-computed expectations for wakeup, age order, full, flush, reset.
module tb_alu_issue_queue;
    import int_iq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_i = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    alu_issue_queue_if io ();

    alu_issue_queue #(.DEPTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .io      (io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        io.disp_valid_i     = 1'b0;
        io.disp_alu_ctrl_i  = '0;
        io.disp_src1_rdy_i  = 1'b0;
        io.disp_src1_tag_i  = '0;
        io.disp_src1_val_i  = '0;
        io.disp_src2_rdy_i  = 1'b0;
        io.disp_src2_tag_i  = '0;
        io.disp_src2_val_i  = '0;
        io.disp_dest_phys_i = '0;
        io.disp_rob_idx_i   = '0;
        io.wb_valid_i       = '0;
        io.wb_tag_i         = '0;
        io.wb_data_i        = '0;
        flush_i             = 1'b0;
    endtask

    task automatic disp(input logic [3:0] c,
                        input logic r1, input logic [6:0] t1,
                        input logic [63:0] v1,
                        input logic r2, input logic [6:0] t2,
                        input logic [63:0] v2,
                        input logic [7:0] rob);
        io.disp_valid_i     = 1'b1;
        io.disp_alu_ctrl_i  = c;
        io.disp_src1_rdy_i  = r1;
        io.disp_src1_tag_i  = t1;
        io.disp_src1_val_i  = v1;
        io.disp_src2_rdy_i  = r2;
        io.disp_src2_tag_i  = t2;
        io.disp_src2_val_i  = v2;
        io.disp_dest_phys_i = rob[6:0];
        io.disp_rob_idx_i   = rob;
    endtask

    task automatic wb(input logic [1:0] v,
                      input logic [6:0] t0, input logic [63:0] d0,
                      input logic [6:0] t1, input logic [63:0] d1);
        io.wb_valid_i = v;
        io.wb_tag_i   = {t1, t0};
        io.wb_data_i  = {d1, d0};
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", 128'(io.disp_ready_o), 128'h1);
        chk("rst_vld", 128'(io.iss_valid_o), 128'h0);
        chk("rst_op1", io.iss_op1_o, 128'h0);
        chk("rst_rob", 128'(io.iss_rob_idx_o), 128'h0);
        rst_n = 1'b1;
        tick();

        // Single ready ADD issues on pipe0 the next cycle
        disp(ALU_ADD, 1, 0, 64'd5, 1, 0, 64'd7, 8'h01);
        tick();
        idle();
        chk("add_vld", 128'(io.iss_valid_o), 128'h1);
        chk("add_op1", io.iss_op1_o, 128'h5);
        chk("add_op2", io.iss_op2_o, 128'h7);
        chk("add_ctl", 128'(io.iss_alu_ctrl_o), 128'h0);
        chk("add_dst", 128'(io.iss_dest_phys_o), 128'h1);
        chk("add_rob", 128'(io.iss_rob_idx_o), 128'h1);
        tick();
        chk("add_free", 128'(io.iss_valid_o), 128'h0);

        // A waits on 12; B and C wait on 20, woken together
        disp(ALU_SUB, 0, 7'd12, 0, 1, 0, 64'd1, 8'h0A);
        tick();
        disp(ALU_AND, 1, 0, 64'd10, 0, 7'd20, 0, 8'h0B);
        tick();
        disp(ALU_OR, 0, 7'd20, 0, 1, 0, 64'd3, 8'h0C);
        tick();
        idle();
        chk("wait_vld", 128'(io.iss_valid_o), 128'h0);
        wb(2'b10, 0, 0, 7'd20, 64'h77);
        tick();
        idle();
        chk("bc_vld", 128'(io.iss_valid_o), 128'h3);
        chk("bc_op1", io.iss_op1_o, {64'h77, 64'hA});
        chk("bc_op2", io.iss_op2_o, {64'h3, 64'h77});
        chk("bc_ctl", 128'(io.iss_alu_ctrl_o), 128'h32);
        chk("bc_rob", 128'(io.iss_rob_idx_o), 128'h0C0B);
        wb(2'b01, 7'd12, 64'hDEAD, 0, 0);
        tick();
        idle();
        chk("a_vld", 128'(io.iss_valid_o), 128'h1);
        chk("a_op1", io.iss_op1_o, 128'hDEAD);
        chk("a_op2", io.iss_op2_o, 128'h1);
        chk("a_ctl", 128'(io.iss_alu_ctrl_o), 128'h01);
        tick();
        chk("a_free", 128'(io.iss_valid_o), 128'h0);

        // Wakeup coinciding with dispatch
        disp(ALU_XOR, 1, 0, 64'd4, 0, 7'd9, 0, 8'h30);
        wb(2'b10, 0, 0, 7'd9, 64'h55);
        tick();
        idle();
        chk("dw_vld", 128'(io.iss_valid_o), 128'h1);
        chk("dw_op1", io.iss_op1_o, 128'h4);
        chk("dw_op2", io.iss_op2_o, 128'h55);
        tick();

        // Both buses hit the same tag: pipe0 data wins
        disp(ALU_SLL, 0, 7'd5, 0, 1, 0, 64'd2, 8'h31);
        tick();
        idle();
        chk("pw_wait", 128'(io.iss_valid_o), 128'h0);
        wb(2'b11, 7'd5, 64'hA0, 7'd5, 64'hB0);
        tick();
        idle();
        chk("pw_op1", io.iss_op1_o, 128'hA0);
        tick();

        // Fill all eight slots with waiting ops
        for (int k = 0; k < 8; k++) begin
            disp(ALU_ADD, 0, 7'(30 + k), 0, 1, 0, 64'(k),
                 8'(8'h40 + k));
            tick();
        end
        idle();
        chk("full_rdy", 128'(io.disp_ready_o), 128'h0);
        disp(ALU_ADD, 1, 0, 64'd1, 1, 0, 64'd1, 8'h4F);
        tick();
        idle();
        chk("full_drop_rdy", 128'(io.disp_ready_o), 128'h0);
        chk("full_drop_vld", 128'(io.iss_valid_o), 128'h0);
        wb(2'b01, 7'd33, 64'h99, 0, 0);
        tick();
        idle();
        chk("full_iss_vld", 128'(io.iss_valid_o), 128'h1);
        chk("full_iss_rob", 128'(io.iss_rob_idx_o), 128'h43);
        chk("full_iss_op1", io.iss_op1_o, 128'h99);
        chk("full_iss_rdy", 128'(io.disp_ready_o), 128'h0);
        tick();
        chk("full_after_rdy", 128'(io.disp_ready_o), 128'h1);
        chk("full_after_vld", 128'(io.iss_valid_o), 128'h0);
        flush_i = 1'b1;
        tick();
        idle();
        chk("clean_rdy", 128'(io.disp_ready_o), 128'h1);

        // Age order over non-contiguous slots: A(s2) B(s0) C(s3) D(s4)
        disp(ALU_SRL, 0, 7'd60, 0, 1, 0, 64'd0, 8'h20);
        tick();
        disp(ALU_SRA, 0, 7'd61, 0, 1, 0, 64'd0, 8'h21);
        tick();
        disp(ALU_ADD, 0, 7'd70, 0, 1, 0, 64'd0, 8'hA0);
        tick();
        disp(ALU_ADD, 0, 7'd60, 0, 1, 0, 64'd0, 8'h23);
        tick();
        idle();
        wb(2'b01, 7'd60, 64'h1, 0, 0);
        tick();
        idle();
        chk("f_vld", 128'(io.iss_valid_o), 128'h3);
        chk("f_rob", 128'(io.iss_rob_idx_o), 128'h2320);
        tick();
        disp(ALU_ADD, 0, 7'd70, 0, 1, 0, 64'd0, 8'hB0);
        tick();
        disp(ALU_ADD, 0, 7'd70, 0, 1, 0, 64'd0, 8'hC0);
        tick();
        disp(ALU_ADD, 0, 7'd70, 0, 1, 0, 64'd0, 8'hD0);
        tick();
        idle();
        wb(2'b01, 7'd70, 64'h2, 0, 0);
        tick();
        idle();
        chk("age1_vld", 128'(io.iss_valid_o), 128'h3);
        chk("age1_rob", 128'(io.iss_rob_idx_o), 128'hB0A0);
        tick();
        chk("age2_vld", 128'(io.iss_valid_o), 128'h3);
        chk("age2_rob", 128'(io.iss_rob_idx_o), 128'hD0C0);
        tick();
        chk("age3_vld", 128'(io.iss_valid_o), 128'h0);

        // Flush with five entries, one ready, plus a concurrent dispatch
        disp(ALU_ADD, 0, 7'd80, 0, 1, 0, 64'd0, 8'hE1);
        tick();
        disp(ALU_ADD, 0, 7'd80, 0, 1, 0, 64'd0, 8'hE2);
        tick();
        disp(ALU_ADD, 0, 7'd80, 0, 1, 0, 64'd0, 8'hE3);
        tick();
        disp(ALU_ADD, 1, 0, 64'd8, 1, 0, 64'd9, 8'hE4);
        tick();
        idle();
        chk("pre_fl_vld", 128'(io.iss_valid_o), 128'h1);
        chk("pre_fl_rob", 128'(io.iss_rob_idx_o), 128'hE4);
        flush_i = 1'b1;
        disp(ALU_ADD, 1, 0, 64'd1, 1, 0, 64'd1, 8'h66);
        #1;
        chk("fl_vld", 128'(io.iss_valid_o), 128'h0);
        tick();
        idle();
        chk("post_fl_rdy", 128'(io.disp_ready_o), 128'h1);
        chk("post_fl_vld", 128'(io.iss_valid_o), 128'h0);
        wb(2'b11, 7'd61, 64'h3, 7'd80, 64'h4);
        tick();
        idle();
        chk("post_fl_wake", 128'(io.iss_valid_o), 128'h0);
        tick();
        chk("post_fl_idle", 128'(io.iss_valid_o), 128'h0);

        // Asynchronous reset mid-stream
        disp(ALU_ADD, 1, 0, 64'd3, 1, 0, 64'd4, 8'h77);
        tick();
        idle();
        chk("ar_pre_vld", 128'(io.iss_valid_o), 128'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld", 128'(io.iss_valid_o), 128'h0);
        chk("ar_rob", 128'(io.iss_rob_idx_o), 128'h0);
        chk("ar_rdy", 128'(io.disp_ready_o), 128'h1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_post_vld", 128'(io.iss_valid_o), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
